// File: rtl/ram_bus_master.sv
// Initiator for the 16x8 asynchronous RAM bus: turns one-cycle requests into
// setup/strobe/hold sequenced RAM cycles, single or auto-incrementing bursts.
module ram_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [3:0] addr_i,
  input  logic [3:0] burst_len_i,
  input  logic [7:0] wdata_i,
  output logic       ready_o,
  output logic       wnext_o,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  output logic       done_o,
  output logic [3:0] ram_address_o,
  output logic [7:0] ram_data_in_o,
  output logic       ram_write_bar_o,
  output logic       ram_read_bar_o,
  output logic       ram_output_enable_o,
  input  logic [7:0] ram_data_out_i
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_we_q;
  logic [3:0]       cur_addr_q;
  logic [3:0]       beats_left_q;

  logic             ready_q;
  logic             wnext_q;
  logic [7:0]       rdata_q;
  logic             rvalid_q;
  logic             done_q;
  logic [3:0]       ram_address_q;
  logic [7:0]       ram_data_in_q;
  logic             ram_write_bar_q;
  logic             ram_read_bar_q;
  logic             ram_oe_q;

  logic [3:0]       cur_addr_d;
  logic [3:0]       beats_left_d;
  logic [CNT_W-1:0] cnt_d;

  assign cur_addr_d   = cur_addr_q + 4'd1;
  assign beats_left_d = beats_left_q - 4'd1;
  assign cnt_d        = cnt_q + CNT_W'(1);

  // Every output comes straight from a flop; values are set on the edge that
  // enters the phase they belong to.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      op_we_q         <= 1'b0;
      cur_addr_q      <= 4'd0;
      beats_left_q    <= 4'd0;
      ready_q         <= 1'b1;
      wnext_q         <= 1'b0;
      rdata_q         <= 8'd0;
      rvalid_q        <= 1'b0;
      done_q          <= 1'b0;
      ram_address_q   <= 4'd0;
      ram_data_in_q   <= 8'd0;
      ram_write_bar_q <= 1'b1;
      ram_read_bar_q  <= 1'b1;
      ram_oe_q        <= 1'b1;
    end else begin
      wnext_q  <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            op_we_q       <= we_i;
            cur_addr_q    <= addr_i;
            beats_left_q  <= burst_len_i;
            ram_address_q <= addr_i;
            if (we_i) ram_data_in_q <= wdata_i;
            cnt_q         <= '0;
            ready_q       <= 1'b0;
            state_q       <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            state_q <= STROBE;
            if (op_we_q) begin
              ram_write_bar_q <= 1'b0;
            end else begin
              ram_read_bar_q <= 1'b0;
              ram_oe_q       <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            cnt_q           <= '0;
            state_q         <= HOLD;
            ram_write_bar_q <= 1'b1;
            ram_read_bar_q  <= 1'b1;
            ram_oe_q        <= 1'b1;
            if (!op_we_q) begin
              rdata_q  <= ram_data_out_i;
              rvalid_q <= 1'b1;
            end
            if (beats_left_q == 4'd0) done_q  <= 1'b1;
            else if (op_we_q)         wnext_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (beats_left_q == 4'd0) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            // Upstream answered wnext with fresh wdata during HOLD.
            beats_left_q  <= beats_left_d;
            cur_addr_q    <= cur_addr_d;
            ram_address_q <= cur_addr_d;
            if (op_we_q) ram_data_in_q <= wdata_i;
            cnt_q         <= '0;
            state_q       <= SETUP;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o             = ready_q;
  assign wnext_o             = wnext_q;
  assign rdata_o             = rdata_q;
  assign rvalid_o            = rvalid_q;
  assign done_o              = done_q;
  assign ram_address_o       = ram_address_q;
  assign ram_data_in_o       = ram_data_in_q;
  assign ram_write_bar_o     = ram_write_bar_q;
  assign ram_read_bar_o      = ram_read_bar_q;
  assign ram_output_enable_o = ram_oe_q;

endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Synchronous initiator for the 16×8 asynchronous RAM bus: address, data_in, write_bar, read_bar and output_enable. It turns single-cycle requests from the datapath/control unit into correctly sequenced RAM cycles: setup, strobe and hold. It supports single accesses and auto-incrementing bursts of up to 16 beats. It sits between the control unit and the RAM and is the only driver of the RAM control pins.

## Interface
- SETUP_CYC, 1, cycles address/data are stable before strobe (≥1)
- STROBE_CYC, 2, cycles strobe is held low (≥1)
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- req  in  1  request; accepted on a cycle with req & ready
- we  in  1  1 = write, 0 = read; sampled at accept
- addr  in  4  start address; sampled at accept
- burst_len  in  4  extra beats (0 = single access, 15 = 16 beats); sampled at accept
- wdata  in  8  write data; sampled at entry to each SETUP phase
- ready  out  1  high only in IDLE
- wnext  out  1  1-cycle pulse in HOLD of every write beat except the last; upstream presents next wdata
- rdata  out  8  read data register
- rvalid  out  1  1-cycle pulse, rdata valid
- done  out  1  1-cycle pulse in HOLD of final beat
- ram_address  out  4  to RAM address
- ram_data_in  out  8  to RAM data_in
- ram_write_bar  out  1  active-low write strobe
- ram_read_bar  out  1  active-low read strobe
- ram_output_enable  out  1  active-low RAM output enable
- ram_data_out  in  8  from RAM data_out

## Operation
- **Reset values:** state IDLE; ready=1; wnext=rvalid=done=0; rdata=0; ram_address=0; ram_data_in=0; ram_write_bar=ram_read_bar=ram_output_enable=1.
- **FSM states:** IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- **IDLE:**
  - On req, latch we/addr/burst_len into the op, cur_addr and beats_left registers.
  - Go to SETUP. req while not ready is ignored, not queued.
- **SETUP (SETUP_CYC cycles):**
  - Drive ram_address=cur_addr.
  - For writes, drive ram_data_in=wdata, sampled on the first SETUP cycle.
  - All strobes high.
- **STROBE (STROBE_CYC cycles):**
  - Write: ram_write_bar=0; ram_read_bar=ram_output_enable=1.
  - Read: ram_read_bar=0 and ram_output_enable=0; ram_write_bar=1.
  - Address and data are held constant.
  - Read: on the last STROBE cycle, register ram_data_out into rdata.
- **HOLD (1 cycle):**
  - All strobes return high; address and data are held.
  - Read: rvalid=1.
  - If beats_left==0: done=1, next state IDLE.
  - Otherwise: beats_left−1; cur_addr+1 mod 16 (15 wraps to 0); next state SETUP; for writes, wnext=1.
- write_bar and read_bar are never low in the same cycle. ram_output_enable is low only during a read STROBE.
- **Reset mid-operation:** the same cycle's synchronous reset forces reset values. An in-flight strobe deasserts on the next edge. The beat is aborted with no done or rvalid.

## Timing
- Accept at edge T0 (IDLE, req=1). With defaults:
  - SETUP during T1.
  - STROBE during T2–T3.
  - HOLD during T4.
  - ready=1 at T5.
- Single access occupies 1+SETUP_CYC+STROBE_CYC+1 cycles, ready to ready. Each further burst beat adds SETUP_CYC+STROBE_CYC+1.
- **Read latency:** rdata/rvalid are visible in HOLD, i.e. 1+SETUP_CYC+STROBE_CYC cycles after accept.
- A back-to-back req held high is accepted again on the first IDLE cycle, with a minimum 1 idle cycle between operations.
- wnext pulses in HOLD. Upstream must present new wdata by the next edge, the first SETUP cycle of the next beat.

## Test plan
- **Single write:** reset, req we=1 addr=3 wdata=0xA5 → ram_write_bar low exactly T2–T3 with ram_address=3 and ram_data_in=0xA5 stable T1–T4; done at T4; ready at T5.
- **Single read:** with a behavioural RAM holding mem[3]=0xA5, read addr=3 → ram_read_bar and ram_output_enable low T2–T3; rdata=0xA5 and rvalid=1 at T4; done=1 at T4.
- **Wrapping write burst:** addr=14, burst_len=3, wdata advanced on each wnext: 0x10,0x11,0x12,0x13 → mem[14]=0x10, mem[15]=0x11, mem[0]=0x12, mem[1]=0x13; 3 wnext pulses; 1 done.
- **Read burst:** a read burst over the same range returns 4 rvalid pulses carrying 0x10,0x11,0x12,0x13.
- **Reset mid-strobe:** rstn=0 during T2 of a write → ram_write_bar=1 by the following edge; no done; ready=1; a subsequent read of the target address shows the RAM model as written or unwritten, with no X on any output.
- **Busy and config checks:**
  - req during SETUP/STROBE is ignored: only one operation executes.
  - Strobes are never both low, checked by assertion across all scenarios.
  - Rerun with SETUP_CYC=2, STROBE_CYC=1 and confirm latencies scale per the Timing section.
